// File: rtl/i2c_slave_rx_tx.sv
// I2C target with a fixed 7-bit address: accepts master writes into rx_data and
// returns tx_data on master reads. The bus is oversampled by clk; SDA is open-drain via sda_oe.
module i2c_slave_rx_tx #(
  parameter logic [6:0] SLAVE_ADDR = 7'd8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       addr_hit
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  scl_sr, sda_sr;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_q;
  logic        rd_acked;

  // Two synchronizer flops, the third stage only provides the previous value for edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sr <= 3'b111;
      sda_sr <= 3'b111;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      scl_sr <= {scl_sr[1:0], scl_in};
      sda_sr <= {sda_sr[1:0], sda_in};
    end
  end

  logic scl_s, scl_d, sda_s, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det, event_ok;
  assign scl_s     = scl_sr[1];
  assign scl_d     = scl_sr[2];
  assign sda_s     = sda_sr[1];
  assign sda_d     = sda_sr[2];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign event_ok  = ~start_det & ~stop_det;

  logic addr_match;
  assign addr_match = (shift_q[6:0] == SLAVE_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: a default for every combinational output first, so no path can infer a latch.
    state_d = state_q;
    if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR:     if (scl_rise && bit_cnt == 4'd7) state_d = addr_match ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (scl_fall && sda_oe) state_d = shift_q[0] ? RD_DATA : WR_DATA;
        WR_DATA:  if (scl_rise && bit_cnt == 4'd7) state_d = WR_ACK;
        WR_ACK:   if (scl_fall && sda_oe) state_d = WR_DATA;
        RD_DATA:  if (scl_fall && bit_cnt == 4'd8) state_d = RD_ACK;
        RD_ACK: begin
          if (scl_rise && sda_s)         state_d = WAIT_STOP;
          else if (scl_fall && rd_acked) state_d = RD_DATA;
        end
        default:  state_d = state_q;
      endcase
    end
  end

  // Per-state datapath strobes; bus conditions suppress every bit-level action.
  logic shift_in, addr_done, rx_load, ack_drive, ack_end, rd_rise, rd_next, rd_done;
  logic ack_sample, load_tx, bus_release;
  always_comb begin
    shift_in    = 1'b0;
    addr_done   = 1'b0;
    rx_load     = 1'b0;
    ack_drive   = 1'b0;
    ack_end     = 1'b0;
    rd_rise     = 1'b0;
    rd_next     = 1'b0;
    rd_done     = 1'b0;
    ack_sample  = 1'b0;
    load_tx     = 1'b0;
    bus_release = 1'b0;
    if (event_ok) begin
      case (state_q)
        ADDR: begin
          shift_in    = scl_rise;
          addr_done   = scl_rise && bit_cnt == 4'd7;
          bus_release = scl_fall;
        end
        ADDR_ACK, WR_ACK: begin
          // sda_oe doubles as the phase flag: low before the 8th fall, high until the 9th.
          ack_drive = scl_fall & ~sda_oe;
          ack_end   = scl_fall & sda_oe;
          load_tx   = scl_fall & sda_oe & shift_q[0] & (state_q == ADDR_ACK);
        end
        WR_DATA: begin
          shift_in = scl_rise;
          rx_load  = scl_rise && bit_cnt == 4'd7;
        end
        RD_DATA: begin
          rd_rise = scl_rise;
          rd_next = scl_fall && bit_cnt != 4'd8;
          rd_done = scl_fall && bit_cnt == 4'd8;
        end
        RD_ACK: begin
          ack_sample = scl_rise;
          load_tx    = scl_fall & rd_acked;
        end
        default: bus_release = scl_fall;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_oe   <= 1'b0;
      tx_req   <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
      busy     <= 1'b0;
      addr_hit <= 1'b0;
      bit_cnt  <= 4'd0;
      shift_q  <= 8'h00;
      rd_acked <= 1'b0;
    end else begin
      rx_valid <= rx_load;
      tx_req   <= load_tx;
      if (start_det) begin
        bit_cnt  <= 4'd0;
        busy     <= 1'b1;
        addr_hit <= 1'b0;
      end else if (stop_det) begin
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        addr_hit <= 1'b0;
        bit_cnt  <= 4'd0;
      end else begin
        if (shift_in) begin
          shift_q <= {shift_q[6:0], sda_s};
          bit_cnt <= bit_cnt + 4'd1;
        end
        if (addr_done && addr_match) addr_hit <= 1'b1;
        if (rx_load)   rx_data <= {shift_q[6:0], sda_s};
        if (ack_drive) sda_oe  <= 1'b1;
        if (ack_end) begin
          sda_oe  <= 1'b0;
          bit_cnt <= 4'd0;
        end
        if (rd_rise) bit_cnt <= bit_cnt + 4'd1;
        if (rd_next) begin
          shift_q <= {shift_q[6:0], 1'b0};
          sda_oe  <= ~shift_q[6];
        end
        if (rd_done) begin
          sda_oe   <= 1'b0;
          rd_acked <= 1'b0;
        end
        if (ack_sample) rd_acked <= ~sda_s;
        // Later assignments win: a read load overrides the ACK release on the same fall.
        if (load_tx) begin
          shift_q <= tx_data;
          sda_oe  <= ~tx_data[7];
          bit_cnt <= 4'd0;
        end
        if (bus_release) sda_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx_tx.sv
// Bench for i2c_slave_rx_tx: a bit-banged bus master plus a transaction-level model whose
// expected bytes are queued and consumed by monitors watching rx_valid / tx_req.
module tb_i2c_slave_rx_tx;

  localparam logic [6:0] SLAVE_ADDR = 7'd8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       sda_m;
  logic       sda_bus;
  logic [7:0] tx_data;
  logic       sda_oe, tx_req, rx_valid, busy, addr_hit;
  logic [7:0] rx_data;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_rx_tx #(.SLAVE_ADDR(SLAVE_ADDR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .addr_hit (addr_hit)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_rx [$];
  logic [7:0] exp_tx [$];
  logic [7:0] payload [8];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected DUT pulse (t=%0t)", name, $time);
  endtask

  // Monitors: every output pulse consumes one expectation from the model queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) fail_event("rx_valid_extra");
        else check("rx_data", rx_data, exp_rx.pop_front());
      end
      if (tx_req) begin
        if (exp_tx.size() == 0) fail_event("tx_req_extra");
        else check("tx_req_sample", tx_data, exp_tx.pop_front());
      end
    end
  end

  // SDA drive may only move while the pin SCL is low.
  logic sda_oe_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sda_oe !== sda_oe_prev) check("sda_oe_change_scl_low", scl, 1'b0);
    sda_oe_prev = sda_oe;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_q();
    repeat (4) @(negedge clk);
  endtask

  // One SCL cycle, entered and left with SCL low; s is SDA as seen by the master while SCL is high.
  task automatic bus_bit(input logic b, output logic s);
    wait_q(); sda_m = b;
    wait_q(); scl = 1'b1;
    wait_q(); s = sda_bus;
    wait_q(); scl = 1'b0;
  endtask

  task automatic bus_start();
    wait_q(); sda_m = 1'b0;
    wait_q(); scl = 1'b0;
  endtask

  task automatic bus_rstart();
    wait_q(); sda_m = 1'b1;
    wait_q(); scl = 1'b1;
    wait_q(); sda_m = 1'b0;
    wait_q(); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_q(); sda_m = 1'b0;
    wait_q(); scl = 1'b1;
    wait_q(); sda_m = 1'b1;
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_bits(output logic [7:0] b);
    logic s;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, s);
      b = {b[6:0], s};
    end
  endtask

  // Master write of n payload bytes; the target ACKs and delivers each byte only if addressed.
  task automatic write_txn(input logic [6:0] addr, input int n);
    logic ack;
    logic hit;
    hit = (addr == SLAVE_ADDR);
    send_byte({addr, 1'b0}, ack);
    check("wr_addr_ack", ack, hit);
    check("wr_addr_hit", addr_hit, hit);
    for (int k = 0; k < n; k++) begin
      if (hit) exp_rx.push_back(payload[k]);
      send_byte(payload[k], ack);
      check("wr_data_ack", ack, hit);
    end
  endtask

  // Master read of n bytes, ACKing all but the last; payload holds what tx_data presents.
  task automatic read_txn(input logic [6:0] addr, input int n);
    logic ack, s;
    logic hit;
    logic [7:0] b;
    hit = (addr == SLAVE_ADDR);
    tx_data = payload[0];
    if (hit) exp_tx.push_back(payload[0]);
    send_byte({addr, 1'b1}, ack);
    check("rd_addr_ack", ack, hit);
    check("rd_addr_hit", addr_hit, hit);
    for (int k = 0; k < n; k++) begin
      recv_bits(b);
      check("rd_byte", b, hit ? payload[k] : 8'hFF);
      if (k < n - 1) begin
        tx_data = payload[k + 1];
        if (hit) exp_tx.push_back(payload[k + 1]);
        bus_bit(1'b0, s);
      end else begin
        bus_bit(1'b1, s);
      end
    end
    check("rd_busy_before_stop", busy, 1'b1);
  endtask

  task automatic finish_stop();
    bus_stop();
    repeat (4) @(negedge clk);
    check("busy_after_stop", busy, 1'b0);
    check("addr_hit_after_stop", addr_hit, 1'b0);
    check("sda_oe_after_stop", sda_oe, 1'b0);
  endtask

  initial begin
    logic ack, s;
    logic [6:0] a;
    rst_n   = 1'b0;
    scl     = 1'b1;
    sda_m   = 1'b1;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addr_hit", addr_hit, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_req", tx_req, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Clocking a matching address without a START must be ignored.
    scl = 1'b0;
    send_byte(8'h10, ack);
    check("no_start_ack", ack, 1'b0);
    check("no_start_busy", busy, 1'b0);
    wait_q(); scl = 1'b1;
    wait_q();

    // Plain write.
    bus_start();
    check("start_busy", busy, 1'b1);
    payload[0] = 8'h0A;
    write_txn(7'h08, 1);
    finish_stop();

    // Read with NACK.
    bus_start();
    payload[0] = 8'hA5;
    read_txn(7'h08, 1);
    finish_stop();

    // Address mismatch.
    bus_start();
    payload[0] = 8'h55;
    write_txn(7'h09, 1);
    finish_stop();

    // Write, repeated START, two-byte read.
    bus_start();
    payload[0] = 8'h3C;
    write_txn(7'h08, 1);
    bus_rstart();
    check("rstart_busy", busy, 1'b1);
    payload[0] = 8'h7E;
    payload[1] = 8'h7E;
    read_txn(7'h08, 2);
    finish_stop();
    check("rstart_rx_data", rx_data, 8'h3C);

    // Reset asserted while the target drives bit 4 of an all-zero read byte.
    bus_start();
    tx_data = 8'h00;
    exp_tx.push_back(8'h00);
    send_byte({7'h08, 1'b1}, ack);
    check("rstmid_addr_ack", ack, 1'b1);
    for (int i = 0; i < 3; i++) bus_bit(1'b1, s);
    wait_q();
    check("rstmid_driving", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstmid_sda_oe", sda_oe, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    sda_m = 1'b1;
    scl   = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_start();
    payload[0] = 8'h01;
    write_txn(7'h08, 1);
    finish_stop();
    check("rstmid_rx_data", rx_data, 8'h01);

    // Randomized transactions against the transaction-level model.
    for (int t = 0; t < 20; t++) begin
      int n;
      if ($urandom_range(0, 3) == 0) begin
        do a = 7'($urandom); while (a == SLAVE_ADDR);
      end else begin
        a = SLAVE_ADDR;
      end
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) payload[k] = 8'($urandom);
      bus_start();
      if ($urandom_range(0, 1) == 1) read_txn(a, n);
      else write_txn(a, n);
      finish_stop();
    end

    repeat (8) @(negedge clk);
    check("rx_queue_drained", exp_rx.size(), 0);
    check("tx_queue_drained", exp_tx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
